// File: rtl/keccak_squeeze.sv
// keccak_squeeze: squeeze side of the SHA-3 sponge.
// Takes a permuted Keccak state and sends its rate lanes out one lane per
// word on a valid/ready stream. The final word is flagged with out_last.
//
// State layout: lane A[x][y] sits at st_in[LANE_W*(5*y+x) +: LANE_W].
// Lane k of the squeeze order (x = k%5, y = k/5) is therefore slice k.
//
// Build option: define KECCAK_SQUEEZE_XOF_EN for SHAKE (XOF) mode.
//   - The digest length comes from out_len, sampled when the state is accepted.
//   - After the last rate lane, if words remain, the block requests another
//     Keccak-f through perm_req/perm_ack and then continues from lane 0.
//   - In the default build the digest length is fixed at OUT_WORDS.
//
// Ports:
//   clk, rst_n        clock; synchronous active-low reset
//   st_valid/st_ready input state handshake (st_ready is high only in idle)
//   st_in             permuted state, 25 lanes
//   out_valid/ready   output word handshake
//   out_data          output word (lane value); out_last marks the final word
//   busy              high whenever the FSM is not idle
//   out_len           (XOF) requested number of words
//   perm_req          (XOF) request one permutation of perm_state
//   perm_state        (XOF) buffered state to permute
//   perm_ack          (XOF) perm_result is valid this cycle
//   perm_result       (XOF) permuted state returned by the permutation
module keccak_squeeze #(
  parameter int unsigned RATE_LANES = 17,
  parameter int unsigned OUT_WORDS  = 4,
  parameter int unsigned LANE_W     = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 st_valid,
  output logic                 st_ready,
  input  logic [25*LANE_W-1:0] st_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LANE_W-1:0]    out_data,
  output logic                 out_last,
  output logic                 busy
`ifdef KECCAK_SQUEEZE_XOF_EN
  ,
  input  logic [15:0]          out_len,
  output logic                 perm_req,
  output logic [25*LANE_W-1:0] perm_state,
  input  logic                 perm_ack,
  input  logic [25*LANE_W-1:0] perm_result
`endif
);

  localparam int unsigned NumLanes = 25;

  if (RATE_LANES == 0 || RATE_LANES > NumLanes) begin : g_bad_rate
    $error("keccak_squeeze: RATE_LANES must be in 1..25");
  end
  if (OUT_WORDS == 0 || OUT_WORDS > RATE_LANES) begin : g_bad_words
    $error("keccak_squeeze: OUT_WORDS must be in 1..RATE_LANES");
  end

`ifdef KECCAK_SQUEEZE_XOF_EN
  typedef enum logic [1:0] {StIdle, StEmit, StPermWait} state_e;
`else
  typedef enum logic [1:0] {StIdle, StEmit} state_e;
`endif

  state_e              state_q, state_d;
  logic [LANE_W-1:0]   buf_q [NumLanes];
  logic [LANE_W-1:0]   buf_d [NumLanes];
  logic [4:0]          lane_idx_q, lane_idx_d;
  logic [15:0]         word_cnt_q, word_cnt_d;
  logic [15:0]         total;
  logic                zero_len;
  logic                last_word;

`ifdef KECCAK_SQUEEZE_XOF_EN
  logic [15:0] len_q, len_d;
  logic        rate_end;

  assign total    = len_q;
  assign rate_end = (lane_idx_q == 5'(RATE_LANES - 1));

  always_comb begin
    for (int i = 0; i < int'(NumLanes); i++) begin
      perm_state[i*LANE_W +: LANE_W] = buf_q[i];
    end
  end
`else
  assign total = 16'(OUT_WORDS);
`endif

  // A zero-length request still takes one EMIT cycle, with out_valid held low.
  assign zero_len  = (total == 16'd0);
  // 17-bit compare so that total-1 never underflows.
  assign last_word = ({1'b0, word_cnt_q} + 17'd1) == {1'b0, total};

  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    lane_idx_d = lane_idx_q;
    word_cnt_d = word_cnt_q;
    st_ready   = 1'b0;
    out_valid  = 1'b0;
`ifdef KECCAK_SQUEEZE_XOF_EN
    len_d      = len_q;
    perm_req   = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        st_ready = 1'b1;
        if (st_valid) begin
          for (int i = 0; i < int'(NumLanes); i++) begin
            buf_d[i] = st_in[i*LANE_W +: LANE_W];
          end
          lane_idx_d = '0;
          word_cnt_d = '0;
`ifdef KECCAK_SQUEEZE_XOF_EN
          len_d      = out_len;
`endif
          state_d    = StEmit;
        end
      end
      StEmit: begin
        if (zero_len) begin
          state_d = StIdle;
        end else begin
          out_valid = 1'b1;
          if (out_ready) begin
            word_cnt_d = word_cnt_q + 16'd1;
            lane_idx_d = lane_idx_q + 5'd1;
            if (last_word) begin
              state_d = StIdle;
`ifdef KECCAK_SQUEEZE_XOF_EN
            end else if (rate_end) begin
              state_d = StPermWait;
`endif
            end
          end
        end
      end
`ifdef KECCAK_SQUEEZE_XOF_EN
      StPermWait: begin
        perm_req = 1'b1;
        if (perm_ack) begin
          for (int i = 0; i < int'(NumLanes); i++) begin
            buf_d[i] = perm_result[i*LANE_W +: LANE_W];
          end
          lane_idx_d = '0;
          state_d    = StEmit;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  assign busy     = (state_q != StIdle);
  assign out_data = out_valid ? buf_q[lane_idx_q] : '0;
  assign out_last = out_valid && last_word;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      buf_q      <= '{default: '0};
      lane_idx_q <= '0;
      word_cnt_q <= '0;
`ifdef KECCAK_SQUEEZE_XOF_EN
      len_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      lane_idx_q <= lane_idx_d;
      word_cnt_q <= word_cnt_d;
`ifdef KECCAK_SQUEEZE_XOF_EN
      len_q      <= len_d;
`endif
    end
  end

endmodule

// File: tb/tb_keccak_squeeze.sv
module tb_keccak_squeeze;

  localparam int LW  = 64;
  localparam int StW = 25 * LW;
`ifdef KECCAK_SQUEEZE_XOF_EN
  localparam int RATE = 21;
`else
  localparam int RATE = 17;
`endif
  localparam int OW = 4;

  logic           clk;
  logic           rst_n;
  logic           st_valid;
  logic           st_ready;
  logic [StW-1:0] st_in;
  logic           out_valid;
  logic           out_ready;
  logic [LW-1:0]  out_data;
  logic           out_last;
  logic           busy;
`ifdef KECCAK_SQUEEZE_XOF_EN
  logic [15:0]    out_len;
  logic           perm_req;
  logic [StW-1:0] perm_state;
  logic           perm_ack;
  logic [StW-1:0] perm_result;
`endif

  int errors = 0;
  int checks = 0;

  // Model: the digest is lanes 0..RATE-1 of blocks[0], then of blocks[1], ...
  logic [StW-1:0] blocks [4];

  keccak_squeeze #(
    .RATE_LANES(RATE),
    .OUT_WORDS (OW),
    .LANE_W    (LW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .st_valid   (st_valid),
    .st_ready   (st_ready),
    .st_in      (st_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy)
`ifdef KECCAK_SQUEEZE_XOF_EN
    ,
    .out_len    (out_len),
    .perm_req   (perm_req),
    .perm_state (perm_state),
    .perm_ack   (perm_ack),
    .perm_result(perm_result)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [StW-1:0] rand_state();
    logic [StW-1:0] s;
    for (int i = 0; i < StW / 32; i++) s[i*32 +: 32] = $urandom();
    return s;
  endfunction

  task automatic capture(input logic [StW-1:0] s);
    int w = 0;
    @(negedge clk);
    while (st_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (st_ready !== 1'b1) begin
      errors++;
      $display("FAIL capture_ready: st_ready=%b, required 1", st_ready);
    end
    st_valid  = 1'b1;
    st_in     = s;
    blocks[0] = s;
  endtask

  // mode 0: out_ready always 1; 1: pattern 1,0,0,1; 2: random out_ready
  task automatic drain(input int total, input int mode, input int ack_dly);
    int             got = 0;
    int             cyc = 0;
    int             pw = 0;
    logic           stalled = 1'b0;
    logic [LW-1:0]  hold_d = '0;
    logic           hold_l = 1'b0;
    logic [LW-1:0]  exp_d;
    logic           exp_l;
    logic [StW-1:0] s;
    logic [3:0]     pat = 4'b1001;
    while (got < total && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      st_valid = 1'b0;
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = pat[(cyc - 1) % 4];
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (stalled) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== hold_d || out_last !== hold_l) begin
          errors++;
          $display("FAIL stall_hold: valid=%b data=%h last=%b, required valid=1 data=%h last=%b",
                   out_valid, out_data, out_last, hold_d, hold_l);
        end
      end
`ifdef KECCAK_SQUEEZE_XOF_EN
      perm_ack = 1'b0;
      if (perm_req === 1'b1) begin
        if (pw == 0) begin
          s = blocks[got / RATE - 1];
          checks++;
          if (perm_state !== s || out_valid !== 1'b0 || (got % RATE) != 0) begin
            errors++;
            $display("FAIL perm_state: valid=%b words=%0d state_ok=%b, required valid=0 words=k*%0d state_ok=1",
                     out_valid, got, perm_state === s, RATE);
          end
        end
        pw++;
        if (pw > ack_dly) begin
          perm_ack    = 1'b1;
          perm_result = blocks[got / RATE];
          pw          = 0;
        end
        stalled = 1'b0;
      end else
`endif
      begin
        if (mode == 0) begin
          checks++;
          if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL consecutive: word %0d out_valid=%b, required 1", got, out_valid);
          end
        end
        if (out_valid === 1'b1) begin
          s     = blocks[got / RATE];
          exp_d = s[(got % RATE) * LW +: LW];
          exp_l = (got == total - 1);
          checks++;
          if (out_data !== exp_d || out_last !== exp_l) begin
            errors++;
            $display("FAIL word%0d: data=%h last=%b, required data=%h last=%b",
                     got, out_data, out_last, exp_d, exp_l);
          end
          if (out_ready) begin
            got++;
            stalled = 1'b0;
          end else begin
            stalled = 1'b1;
            hold_d  = out_data;
            hold_l  = out_last;
          end
        end else begin
          stalled = 1'b0;
        end
      end
    end
    checks++;
    if (got < total) begin
      errors++;
      $display("FAIL drain_timeout: words=%0d, required %0d", got, total);
    end
    @(negedge clk);
    out_ready = 1'b0;
`ifdef KECCAK_SQUEEZE_XOF_EN
    perm_ack = 1'b0;
`endif
    checks++;
    if (out_valid !== 1'b0 || st_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL drain_end: valid=%b st_ready=%b busy=%b, required 0 1 0",
               out_valid, st_ready, busy);
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    st_valid  = 1'b1;
    st_in     = rand_state();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || out_last !== 1'b0 || out_data !== '0) begin
        errors++;
        $display("FAIL reset_hold: valid=%b busy=%b last=%b data=%h, required 0 0 0 0",
                 out_valid, busy, out_last, out_data);
      end
    end
    rst_n     = 1'b1;
    st_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (st_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: st_ready=%b busy=%b valid=%b, required 1 0 0",
               st_ready, busy, out_valid);
    end
  endtask

  task automatic test_abc();
    logic [StW-1:0] s = rand_state();
    s[0*LW +: LW] = 64'h3a985da74fe225b2;
    s[1*LW +: LW] = 64'h045c172d6bd390bd;
    s[2*LW +: LW] = 64'h855f086e3e9d525b;
    s[3*LW +: LW] = 64'h46bfe24511431532;
    capture(s);
    drain(OW, 0, 0);
  endtask

  task automatic test_backpressure();
    capture(rand_state());
    drain(OW, 1, 0);
  endtask

  task automatic test_reset_mid();
    logic [StW-1:0] s = rand_state();
    logic [LW-1:0]  exp_d = s[2*LW +: LW];
    capture(s);
    @(negedge clk);
    st_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== exp_d) begin
      errors++;
      $display("FAIL mid_word2: valid=%b data=%h, required 1 %h", out_valid, out_data, exp_d);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: valid=%b busy=%b last=%b, required 0 0 0",
               out_valid, busy, out_last);
    end
    rst_n     = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (st_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_idle: st_ready=%b valid=%b, required 1 0", st_ready, out_valid);
    end
    capture(rand_state());
    drain(OW, 0, 0);
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 5; n++) begin
      capture(rand_state());
      drain(OW, 2, 0);
    end
  endtask

`ifdef KECCAK_SQUEEZE_XOF_EN
  task automatic test_xof_long();
    out_len   = 16'd25;
    blocks[1] = rand_state();
    capture(rand_state());
    drain(25, 0, 5);
  endtask

  task automatic test_xof_zero();
    logic exp_rdy;
    out_len = 16'd0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      exp_rdy = (i % 2 == 0);
      checks++;
      if (st_ready !== exp_rdy || busy !== !exp_rdy || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL xof_zero%0d: st_ready=%b busy=%b valid=%b, required %b %b 0",
                 i, st_ready, busy, out_valid, exp_rdy, !exp_rdy);
      end
      st_valid = 1'b1;
      st_in    = rand_state();
    end
    @(negedge clk);
    st_valid = 1'b0;
    checks++;
    if (st_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL xof_zero_end: st_ready=%b busy=%b valid=%b, required 1 0 0",
               st_ready, busy, out_valid);
    end
  endtask

  task automatic test_xof_random();
    int len;
    for (int n = 0; n < 6; n++) begin
      len     = int'($urandom_range(1, 60));
      out_len = 16'(len);
      for (int b = 1; b < 4; b++) blocks[b] = rand_state();
      capture(rand_state());
      drain(len, 2, int'($urandom_range(0, 6)));
    end
    out_len = 16'(OW);
  endtask
`endif

  initial begin
    rst_n     = 1'b0;
    st_valid  = 1'b0;
    st_in     = '0;
    out_ready = 1'b0;
`ifdef KECCAK_SQUEEZE_XOF_EN
    out_len     = 16'(OW);
    perm_ack    = 1'b0;
    perm_result = '0;
`endif
    test_reset();
    test_abc();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
`ifdef KECCAK_SQUEEZE_XOF_EN
    test_xof_long();
    test_xof_zero();
    test_xof_random();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
